// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared types for the EX/MEM stage (access sizes, squash states, ALU opcodes, stage control bundle)
package ex_mem_pkg;
  localparam int DATA_W_DEF = 32;
  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10
  } mem_size_e;
  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } state_e;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       addr_err;
    logic [1:0] mem_size;
    logic [4:0] dest;
  } ctl_t;
endpackage

// File: rtl/ex_mem_stage_align.sv
// mem_align_check: flags a word access off a 4-byte boundary or a half access off a 2-byte boundary
module mem_align_check
  import ex_mem_pkg::*;
(
  input  logic [1:0] addr_i,
  input  logic [1:0] mem_size_i,
  output logic       misaligned_o
);
  assign misaligned_o = (mem_size_i == SZ_WORD) ? |addr_i : (mem_size_i == SZ_HALF) ? addr_i[0] : 1'b0;
endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM register with taken-branch redirect, wrong-path squash and load/store alignment check
module ex_mem_stage
  import ex_mem_pkg::*;
#(
  parameter int SQUASH_DEPTH = 2,
  parameter int DATA_W       = DATA_W_DEF
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              in_Valid,
  input  logic [DATA_W-1:0] in_ALUResult,
  input  logic              in_Zero,
  input  logic [DATA_W-1:0] in_WriteData,
  input  logic [4:0]        in_DestReg,
  input  logic              in_RegWrite,
  input  logic              in_MemRead,
  input  logic              in_MemWrite,
  input  logic              in_MemToReg,
  input  logic [1:0]        in_MemSize,
  input  logic              in_Branch,
  input  logic              in_Jump,
  input  logic [DATA_W-1:0] in_Target,
  output logic              out_Valid,
  output logic [DATA_W-1:0] out_ALUResult,
  output logic [DATA_W-1:0] out_WriteData,
  output logic [4:0]        out_DestReg,
  output logic              out_RegWrite,
  output logic              out_MemRead,
  output logic              out_MemWrite,
  output logic              out_MemToReg,
  output logic [1:0]        out_MemSize,
  output logic              out_AddrErr,
  output logic              Redirect,
  output logic [DATA_W-1:0] RedirectPC
);
  localparam int CW = SQUASH_DEPTH > 0 ? $clog2(SQUASH_DEPTH + 1) : 1;
  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  ctl_t              ctl_q, ctl_d;
  logic [DATA_W-1:0] alu_q, alu_d, wd_q, wd_d, pc_q, pc_d;
  logic              redirect_q, redirect_d;
  logic              squashing, cap, taken, misaligned, err;
  mem_align_check u_align (
    .addr_i       (in_ALUResult[1:0]),
    .mem_size_i   (in_MemSize),
    .misaligned_o (misaligned)
  );
  assign squashing = state_q == SQUASH;
  assign cap       = in_Valid & ~squashing;
  assign taken     = cap & (in_Jump | (in_Branch & in_Zero));
  assign err       = cap & (in_MemRead | in_MemWrite) & misaligned;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ctl_d      = ctl_q;
    alu_d      = alu_q;
    wd_d       = wd_q;
    pc_d       = pc_q;
    redirect_d = 1'b0;
    if (Flush) begin
      state_d         = RUN;
      cnt_d           = '0;
      ctl_d.valid     = 1'b0;
      ctl_d.reg_write = 1'b0;
      ctl_d.mem_read  = 1'b0;
      ctl_d.mem_write = 1'b0;
      ctl_d.addr_err  = 1'b0;
    end else if (!Stall) begin
      alu_d            = in_ALUResult;
      wd_d             = in_WriteData;
      ctl_d.valid      = cap;
      ctl_d.reg_write  = cap & in_RegWrite & ~err;
      ctl_d.mem_read   = cap & in_MemRead & ~err;
      ctl_d.mem_write  = cap & in_MemWrite & ~err;
      ctl_d.mem_to_reg = in_MemToReg;
      ctl_d.addr_err   = err;
      ctl_d.mem_size   = in_MemSize;
      ctl_d.dest       = in_DestReg;
      if (taken) begin
        state_d    = (SQUASH_DEPTH > 0) ? SQUASH : RUN;
        cnt_d      = CW'(SQUASH_DEPTH);
        redirect_d = 1'b1;
        pc_d       = in_Target;
      end else if (squashing && in_Valid) begin
        cnt_d   = cnt_q - CW'(1);
        state_d = (cnt_q == CW'(1)) ? RUN : SQUASH;
      end
    end
  end
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      ctl_q      <= '0;
      alu_q      <= '0;
      wd_q       <= '0;
      pc_q       <= '0;
      redirect_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ctl_q      <= ctl_d;
      alu_q      <= alu_d;
      wd_q       <= wd_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
    end
  end
  assign out_Valid     = ctl_q.valid;
  assign out_ALUResult = alu_q;
  assign out_WriteData = wd_q;
  assign out_DestReg   = ctl_q.dest;
  assign out_RegWrite  = ctl_q.reg_write;
  assign out_MemRead   = ctl_q.mem_read;
  assign out_MemWrite  = ctl_q.mem_write;
  assign out_MemToReg  = ctl_q.mem_to_reg;
  assign out_MemSize   = ctl_q.mem_size;
  assign out_AddrErr   = ctl_q.addr_err;
  assign Redirect      = redirect_q;
  assign RedirectPC    = pc_q;
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed checks of capture, redirect/squash, alignment, stall/flush and async reset
module tb_ex_mem_stage;
  import ex_mem_pkg::*;
  logic        Clk = 1'b0;
  logic        Rst_n, Stall, Flush, in_Valid, in_Zero, in_RegWrite, in_MemRead, in_MemWrite, in_MemToReg, in_Branch, in_Jump;
  logic [31:0] in_ALUResult, in_WriteData, in_Target;
  logic [4:0]  in_DestReg;
  logic [1:0]  in_MemSize;
  logic        out_Valid, out_RegWrite, out_MemRead, out_MemWrite, out_MemToReg, out_AddrErr, Redirect;
  logic [31:0] out_ALUResult, out_WriteData, RedirectPC;
  logic [4:0]  out_DestReg;
  logic [1:0]  out_MemSize;
  int tests = 0;
  int fails = 0;
  ex_mem_stage dut (
    .Clk(Clk), .Rst_n(Rst_n), .Stall(Stall), .Flush(Flush),
    .in_Valid(in_Valid), .in_ALUResult(in_ALUResult), .in_Zero(in_Zero),
    .in_WriteData(in_WriteData), .in_DestReg(in_DestReg),
    .in_RegWrite(in_RegWrite), .in_MemRead(in_MemRead), .in_MemWrite(in_MemWrite),
    .in_MemToReg(in_MemToReg), .in_MemSize(in_MemSize), .in_Branch(in_Branch),
    .in_Jump(in_Jump), .in_Target(in_Target),
    .out_Valid(out_Valid), .out_ALUResult(out_ALUResult), .out_WriteData(out_WriteData),
    .out_DestReg(out_DestReg), .out_RegWrite(out_RegWrite), .out_MemRead(out_MemRead),
    .out_MemWrite(out_MemWrite), .out_MemToReg(out_MemToReg), .out_MemSize(out_MemSize),
    .out_AddrErr(out_AddrErr), .Redirect(Redirect), .RedirectPC(RedirectPC)
  );
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic clr();
    in_Valid = 0; in_ALUResult = 0; in_Zero = 0; in_WriteData = 0; in_DestReg = 0;
    in_RegWrite = 0; in_MemRead = 0; in_MemWrite = 0; in_MemToReg = 0; in_MemSize = 2'b00;
    in_Branch = 0; in_Jump = 0; in_Target = 0;
  endtask
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  initial begin
    Rst_n = 0; Stall = 0; Flush = 0; clr();
    tick(); tick();
    Rst_n = 1;
    chk("rst_valid", out_Valid, 0);
    chk("rst_redirect", Redirect, 0);
    chk("rst_pc", RedirectPC, 0);
    chk("rst_alu", out_ALUResult, 0);
    // plain add
    clr(); in_Valid = 1; in_ALUResult = 32'h10; in_RegWrite = 1; in_DestReg = 5'd3;
    tick();
    chk("add_alu", out_ALUResult, 32'h10);
    chk("add_valid", out_Valid, 1);
    chk("add_redirect", Redirect, 0);
    chk("add_rw", out_RegWrite, 1);
    chk("add_dest", out_DestReg, 3);
    // taken beq followed by three valid instructions
    clr(); in_Valid = 1; in_Branch = 1; in_Zero = 1; in_Target = 32'h0040_0020;
    tick();
    chk("beq_redirect", Redirect, 1);
    chk("beq_pc", RedirectPC, 32'h0040_0020);
    chk("beq_valid", out_Valid, 1);
    chk("beq_state", dut.state_q, 64'(SQUASH));
    chk("beq_cnt", dut.cnt_q, 2);
    clr(); in_Valid = 1; in_ALUResult = 32'h100; in_RegWrite = 1;
    tick();
    chk("sq1_valid", out_Valid, 0);
    chk("sq1_rw", out_RegWrite, 0);
    chk("sq1_redirect", Redirect, 0);
    chk("sq1_cnt", dut.cnt_q, 1);
    clr(); in_Valid = 1; in_ALUResult = 32'h200; in_RegWrite = 1;
    tick();
    chk("sq2_valid", out_Valid, 0);
    chk("sq2_cnt", dut.cnt_q, 0);
    chk("sq2_state", dut.state_q, 64'(RUN));
    clr(); in_Valid = 1; in_ALUResult = 32'h300; in_RegWrite = 1;
    tick();
    chk("post_valid", out_Valid, 1);
    chk("post_alu", out_ALUResult, 32'h300);
    chk("post_redirect", Redirect, 0);
    // jump, idle cycle, wrong-path taken branch
    clr(); in_Valid = 1; in_Jump = 1; in_Target = 32'h500;
    tick();
    chk("j_redirect", Redirect, 1);
    chk("j_pc", RedirectPC, 32'h500);
    clr();
    tick();
    chk("idle_valid", out_Valid, 0);
    chk("idle_cnt", dut.cnt_q, 2);
    chk("idle_redirect", Redirect, 0);
    clr(); in_Valid = 1; in_Branch = 1; in_Zero = 1; in_Target = 32'h900;
    tick();
    chk("wp_redirect", Redirect, 0);
    chk("wp_pc", RedirectPC, 32'h500);
    chk("wp_valid", out_Valid, 0);
    chk("wp_cnt", dut.cnt_q, 1);
    clr(); in_Valid = 1; in_RegWrite = 1;
    tick();
    chk("wp2_cnt", dut.cnt_q, 0);
    chk("wp2_state", dut.state_q, 64'(RUN));
    chk("wp2_valid", out_Valid, 0);
    clr(); in_Valid = 1; in_ALUResult = 32'h44; in_RegWrite = 1;
    tick();
    chk("wp3_valid", out_Valid, 1);
    // alignment
    clr(); in_Valid = 1; in_MemWrite = 1; in_MemSize = 2'b00; in_ALUResult = 32'h1002; in_WriteData = 32'hdeadbeef;
    tick();
    chk("sw_err", out_AddrErr, 1);
    chk("sw_mw", out_MemWrite, 0);
    chk("sw_valid", out_Valid, 1);
    chk("sw_wd", out_WriteData, 32'hdeadbeef);
    clr(); in_Valid = 1; in_MemRead = 1; in_RegWrite = 1; in_MemToReg = 1; in_MemSize = 2'b01; in_ALUResult = 32'h1001;
    tick();
    chk("lh_err", out_AddrErr, 1);
    chk("lh_mr", out_MemRead, 0);
    chk("lh_rw", out_RegWrite, 0);
    chk("lh_valid", out_Valid, 1);
    clr(); in_Valid = 1; in_MemRead = 1; in_RegWrite = 1; in_MemToReg = 1; in_MemSize = 2'b10; in_ALUResult = 32'h1003;
    tick();
    chk("lb_err", out_AddrErr, 0);
    chk("lb_mr", out_MemRead, 1);
    chk("lb_rw", out_RegWrite, 1);
    chk("lb_size", out_MemSize, 2'b10);
    clr(); in_Valid = 1; in_MemWrite = 1; in_MemSize = 2'b01; in_ALUResult = 32'h1002;
    tick();
    chk("sh_err", out_AddrErr, 0);
    chk("sh_mw", out_MemWrite, 1);
    clr(); in_Valid = 1; in_ALUResult = 32'h1003; in_RegWrite = 1;
    tick();
    chk("alu_noerr", out_AddrErr, 0);
    // stall during squash, then flush with stall
    clr(); in_Valid = 1; in_Jump = 1; in_ALUResult = 32'h77; in_Target = 32'h700;
    tick();
    chk("sj_redirect", Redirect, 1);
    Stall = 1; clr(); in_Valid = 1; in_ALUResult = 32'h55; in_RegWrite = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_redirect", Redirect, 0);
      chk("st_valid", out_Valid, 1);
      chk("st_alu", out_ALUResult, 32'h77);
      chk("st_cnt", dut.cnt_q, 2);
      chk("st_state", dut.state_q, 64'(SQUASH));
    end
    Flush = 1;
    tick();
    chk("fl_valid", out_Valid, 0);
    chk("fl_state", dut.state_q, 64'(RUN));
    chk("fl_cnt", dut.cnt_q, 0);
    chk("fl_rw", out_RegWrite, 0);
    Stall = 0; Flush = 0; clr(); in_Valid = 1; in_ALUResult = 32'h66; in_RegWrite = 1;
    tick();
    chk("afl_valid", out_Valid, 1);
    chk("afl_alu", out_ALUResult, 32'h66);
    // flush beats a taken jump on the same edge
    clr(); Flush = 1; in_Valid = 1; in_Jump = 1; in_Target = 32'h800;
    tick();
    chk("fj_redirect", Redirect, 0);
    chk("fj_valid", out_Valid, 0);
    chk("fj_state", dut.state_q, 64'(RUN));
    Flush = 0; clr(); in_Valid = 1; in_ALUResult = 32'h88;
    tick();
    chk("fj2_valid", out_Valid, 1);
    // asynchronous reset mid-squash
    clr(); in_Valid = 1; in_Jump = 1; in_ALUResult = 32'h99; in_Target = 32'ha00;
    tick();
    chk("ar_pre_redirect", Redirect, 1);
    clr();
    #1 Rst_n = 0;
    #1;
    chk("ar_valid", out_Valid, 0);
    chk("ar_redirect", Redirect, 0);
    chk("ar_pc", RedirectPC, 0);
    chk("ar_alu", out_ALUResult, 0);
    chk("ar_state", dut.state_q, 64'(RUN));
    chk("ar_cnt", dut.cnt_q, 0);
    tick();
    Rst_n = 1; in_Valid = 1; in_ALUResult = 32'h11;
    tick();
    chk("ar_post_valid", out_Valid, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
